// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic_pipe slice.
// Stat counters saturate rather than wrap so long soaks stay readable.
package elastic_pipe_pkg;

   localparam int MAX_STAGES = 8;
   localparam int STAT_W     = 16;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
      return (en && (v != {STAT_W{1'b1}})) ? v + STAT_W'(1) : v;
   endfunction

endpackage

// File: rtl/elastic_skid_stage.sv
// One skid stage: main + skid slot, up_ready_o is a pure register output.
// 1 clk latency through main; the skid slot absorbs the beat in flight when downstream stalls.
module elastic_skid_stage #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              up_valid_i,
   input  logic [DATA_W-1:0] up_data_i,
   output logic              up_ready_o,
   output logic              dn_valid_o,
   output logic [DATA_W-1:0] dn_data_o,
   input  logic              dn_ready_i,
   output logic [1:0]        occ_o
);

   typedef struct packed {
      logic              v;
      logic [DATA_W-1:0] d;
   } slot_t;

   slot_t main_q, main_d;
   slot_t skid_q, skid_d;

   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (flush_i) begin
         main_d.v = 1'b0;
         skid_d.v = 1'b0;
      end else if (skid_q.v) begin
         // main is necessarily valid here; refill it from skid as it drains
         if (dn_ready_i) begin
            main_d.d = skid_q.d;
            skid_d.v = 1'b0;
         end
      end else if (up_valid_i) begin
         if (!main_q.v || dn_ready_i) begin
            main_d = '{v: 1'b1, d: up_data_i};
         end else begin
            skid_d = '{v: 1'b1, d: up_data_i};
         end
      end else if (main_q.v && dn_ready_i) begin
         main_d.v = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   assign up_ready_o = ~skid_q.v;
   assign dn_valid_o = main_q.v;
   assign dn_data_o  = main_q.d;
   assign occ_o      = {1'b0, main_q.v} + {1'b0, skid_q.v};

endmodule

// File: rtl/elastic_pipe.sv
// Chain of STAGES skid stages: 1 beat/clk, STAGES cycles latency, in_ready registered (no path from out_ready).
// Synchronous flush and occupancy count; stat counters present only with ELASTIC_PIPE_STATS_EN.
module elastic_pipe
   import elastic_pipe_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = $clog2(2*STAGES+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  count,
   output logic [STAT_W-1:0] stat_xfer,
   output logic [STAT_W-1:0] stat_stall
);

   logic              vld [STAGES+1];
   logic              rdy [STAGES+1];
   logic [DATA_W-1:0] dat [STAGES+1];
   logic [1:0]        occ [STAGES];

   assign vld[0]      = in_valid;
   assign dat[0]      = in_data;
   assign rdy[STAGES] = out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      elastic_skid_stage #(.DATA_W(DATA_W)) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .flush_i    (flush),
         .up_valid_i (vld[k]),
         .up_data_i  (dat[k]),
         .up_ready_o (rdy[k]),
         .dn_valid_o (vld[k+1]),
         .dn_data_o  (dat[k+1]),
         .dn_ready_i (rdy[k+1]),
         .occ_o      (occ[k])
      );
   end

   // flush masks the handshakes so the discard edge can never also transfer
   assign in_ready  = rdy[0] & ~flush;
   assign out_valid = vld[STAGES] & ~flush;
   assign out_data  = dat[STAGES];

   logic in_acc, out_acc;
   assign in_acc  = in_valid & in_ready;
   assign out_acc = out_valid & out_ready;

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q + CNT_W'(in_acc) - CNT_W'(out_acc);
      if (flush) count_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

   logic [CNT_W-1:0] occ_sum;
   always_comb begin
      occ_sum = '0;
      for (int k = 0; k < STAGES; k++) occ_sum = occ_sum + CNT_W'(occ[k]);
   end

   a_count_matches_slots: assert property (@(posedge clk) disable iff (!rst_n) count_q == occ_sum);
   a_stages_in_range:     assert property (@(posedge clk) (STAGES >= 1) && (STAGES <= MAX_STAGES));

`ifdef ELASTIC_PIPE_STATS_EN
   logic [STAT_W-1:0] xfer_q, xfer_d, stall_q, stall_d;

   assign xfer_d  = sat_inc(xfer_q, in_acc);
   assign stall_d = sat_inc(stall_q, out_valid & ~out_ready);

   // not cleared by flush: these describe link history, not pipe contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_q  <= '0;
         stall_q <= '0;
      end else begin
         xfer_q  <= xfer_d;
         stall_q <= stall_d;
      end
   end

   assign stat_xfer  = xfer_q;
   assign stat_stall = stall_q;
`else
   assign stat_xfer  = '0;
   assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed + scoreboard bench for elastic_pipe with DATA_W=8, STAGES=2.
module tb_elastic_pipe;

   localparam int DATA_W = 8;
   localparam int STAGES = 2;
   localparam int CNT_W  = $clog2(2*STAGES+1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CNT_W-1:0]  count;
   logic [15:0]       stat_xfer;
   logic [15:0]       stat_stall;

   int checks   = 0;
   int failures = 0;

   elastic_pipe #(.DATA_W(DATA_W), .STAGES(STAGES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .count      (count),
      .stat_xfer  (stat_xfer),
      .stat_stall (stat_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic       orr;
      logic       fl;
      logic       e_ir;
      logic       e_ov;
      logic       chk_d;
      logic [7:0] e_od;
      logic [2:0] e_cnt;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic orr, input logic fl,
                               input logic e_ir, input logic e_ov, input logic chk_d,
                               input logic [7:0] e_od, input logic [2:0] e_cnt);
      vec_t v;
      v.iv = iv; v.id = id; v.orr = orr; v.fl = fl;
      v.e_ir = e_ir; v.e_ov = e_ov; v.chk_d = chk_d; v.e_od = e_od; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change at negedge; outputs are sampled 1 time unit later, well before the next posedge.
   task automatic step(input logic iv, input logic [7:0] d, input logic orr, input logic fl);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = orr;
      flush     = fl;
      #1;
   endtask

   logic [7:0] q[$];

   initial begin
      int acc;
      int n;
      int first_ir;
      int sent;
      int rcvd;
      int cyc;
      logic took;
      logic [7:0] exp_d;

      // Columns: in_valid, in_data, out_ready, flush | in_ready, out_valid, check data?, out_data, count
      vecs[0]  = mk(1'b1, 8'h11, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 8'h00, 3'd0);
      vecs[1]  = mk(1'b1, 8'h22, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 8'h00, 3'd1);
      vecs[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 8'h11, 3'd2);
      vecs[3]  = mk(1'b1, 8'h33, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 8'h11, 3'd2);
      vecs[4]  = mk(1'b1, 8'h44, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 8'h11, 3'd3);
      vecs[5]  = mk(1'b1, 8'h55, 1'b0, 1'b0,  1'b0, 1'b1, 1'b1, 8'h11, 3'd4);
      vecs[6]  = mk(1'b1, 8'h55, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 8'h11, 3'd4);
      vecs[7]  = mk(1'b1, 8'h55, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 8'h22, 3'd3);
      vecs[8]  = mk(1'b1, 8'h55, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 8'h33, 3'd2);
      vecs[9]  = mk(1'b0, 8'h00, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 8'h00, 3'd2);
      vecs[10] = mk(1'b1, 8'h66, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
      vecs[11] = mk(1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 8'h00, 3'd1);
      vecs[12] = mk(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 8'h66, 3'd1);
      vecs[13] = mk(1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 8'h66, 3'd1);
      vecs[14] = mk(1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 8'h00, 3'd0);

      // ---------------- reset then idle
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset in_ready",  32'(in_ready),  32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset count",     32'(count),     32'd0);
      chk("reset out_data",  32'(out_data),  32'd0);
      chk("reset stat_xfer", 32'(stat_xfer), 32'd0);

      // ---------------- table: fill, full, drain, flush, single beat
      for (int i = 0; i < 15; i++) begin
         step(vecs[i].iv, vecs[i].id, vecs[i].orr, vecs[i].fl);
         chk($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         chk($sformatf("vec%0d count", i),     32'(count),     32'(vecs[i].e_cnt));
         if (vecs[i].chk_d)
            chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      end

      // ---------------- streaming: beat presented in cycle t leaves in cycle t+STAGES
      for (int t = 0; t < 16 + STAGES + 1; t++) begin
         step(t < 16, 8'(t + 1), 1'b1, 1'b0);
         if (t < 16) chk($sformatf("stream in_ready t%0d", t), 32'(in_ready), 32'd1);
         if (t >= STAGES && t < 16 + STAGES) begin
            chk($sformatf("stream out_valid t%0d", t), 32'(out_valid), 32'd1);
            chk($sformatf("stream out_data t%0d", t),  32'(out_data),  32'(t - STAGES + 1));
         end else begin
            chk($sformatf("stream out_valid t%0d", t), 32'(out_valid), 32'd0);
         end
         if (t >= STAGES && t <= 16) chk($sformatf("stream count t%0d", t), 32'(count), 32'd2);
      end
      chk("stream count drained", 32'(count), 32'd0);

      // ---------------- fill under backpressure, then drain
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         step(1'b1, 8'hA0 + 8'(acc), 1'b0, 1'b0);
         if (in_ready) acc++;
      end
      chk("fill accepted", 32'(acc),      32'd4);
      chk("fill in_ready", 32'(in_ready), 32'd0);
      chk("fill count",    32'(count),    32'd4);
      n = 0;
      first_ir = -1;
      for (int c = 0; c < 12; c++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         if (in_ready && first_ir < 0) first_ir = c;
         if (out_valid) begin
            chk($sformatf("drain data %0d", n), 32'(out_data), 32'(8'hA0 + 8'(n)));
            n++;
         end
      end
      chk("drain beats",        32'(n),        32'd4);
      chk("drain ir return",    32'(first_ir), 32'd2);
      chk("drain in_ready",     32'(in_ready), 32'd1);
      chk("drain count",        32'(count),    32'd0);

      // ---------------- flush at count=3 with in_valid held high
      step(1'b1, 8'hC1, 1'b0, 1'b0);
      step(1'b1, 8'hC2, 1'b0, 1'b0);
      step(1'b1, 8'hC3, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("preflush count", 32'(count), 32'd3);
      step(1'b1, 8'h77, 1'b1, 1'b1);
      chk("flush in_ready",  32'(in_ready),  32'd0);
      chk("flush out_valid", 32'(out_valid), 32'd0);
      step(1'b1, 8'h77, 1'b1, 1'b1);
      chk("flush2 count",    32'(count),     32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("postflush count",     32'(count),     32'd0);
      chk("postflush out_valid", 32'(out_valid), 32'd0);
      chk("postflush in_ready",  32'(in_ready),  32'd1);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      chk("0x55 accepted", 32'(in_ready), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("0x55 not yet", 32'(out_valid), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("0x55 out_valid", 32'(out_valid), 32'd1);
      chk("0x55 out_data",  32'(out_data),  32'h55);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("0x55 gone", 32'(count), 32'd0);

      // ---------------- random valid/ready scoreboard
      sent = 0; rcvd = 0; cyc = 0; took = 1'b0;
      in_valid = 1'b0;
      while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
         @(negedge clk);
         if (took) in_valid = 1'b0;
         if (!in_valid && sent < 1000 && $urandom_range(1, 0) == 1) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
         end
         out_ready = ($urandom_range(1, 0) == 1);
         flush = 1'b0;
         #1;
         chk("rand count", 32'(count), 32'(q.size()));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("rand spurious output", 32'd1, 32'd0);
            end else begin
               exp_d = q.pop_front();
               chk($sformatf("rand data %0d", rcvd), 32'(out_data), 32'(exp_d));
            end
            rcvd++;
         end
         took = in_valid && in_ready;
         if (took) begin
            q.push_back(in_data);
            sent++;
         end
         cyc++;
      end
      chk("rand within budget", 32'(cyc < 20000), 32'd1);
      chk("rand received",      32'(rcvd),        32'd1000);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // ---------------- reset in the middle of traffic
      step(1'b1, 8'hE1, 1'b0, 1'b0);
      step(1'b1, 8'hE2, 1'b0, 1'b0);
      step(1'b1, 8'hE3, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midreset out_valid", 32'(out_valid), 32'd0);
      chk("midreset count",     32'(count),     32'd0);
      chk("midreset in_ready",  32'(in_ready),  32'd1);
      chk("midreset out_data",  32'(out_data),  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // ---------------- stats: 20 transfers, then 7 stalled cycles
      for (int t = 0; t < 20; t++) step(1'b1, 8'(t), 1'b1, 1'b0);
      for (int t = 0; t < 7; t++)  step(1'b0, 8'h00, 1'b0, 1'b0);
      for (int t = 0; t < 4; t++)  step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef ELASTIC_PIPE_STATS_EN
      chk("stat_xfer 20",  32'(stat_xfer),  32'd20);
      chk("stat_stall 7",  32'(stat_stall), 32'd7);
      for (int c = 0; c < 65600; c++) step(1'b1, 8'(c), 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("stat_xfer saturated", 32'(stat_xfer),  32'hFFFF);
      chk("stat_stall held",     32'(stat_stall), 32'd7);
`else
      chk("stat_xfer tied",  32'(stat_xfer),  32'd0);
      chk("stat_stall tied", 32'(stat_stall), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
